// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8N1-style framing, mid-bit sampling, valid/ready word output
// Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote at every sample point.
module uart_rx #(
  parameter int DW        = 8,
  parameter int SYS_FREQ  = 100000000,
  parameter int BAUD_FREQ = 9600
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_ser,
  output logic [DW-1:0] rx_par,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          frame_err,
  output logic          overrun
);

  localparam int CLK_DIVISOR = SYS_FREQ / BAUD_FREQ;
  localparam int HALF        = CLK_DIVISOR / 2;
  localparam int CW          = (CLK_DIVISOR > 1) ? $clog2(CLK_DIVISOR) : 1;
  localparam int BW          = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [DW-1:0] shreg, shreg_nxt;
  logic          load, ferr_set;
  logic          sync1, rx_sync, sample;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1   <= rx_ser;
      rx_sync <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist1, hist2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= rx_sync;
      hist2 <= hist1;
    end
  end

  // A single-cycle glitch on the line cannot flip the vote of three consecutive samples.
  assign sample = (rx_sync & hist1) | (rx_sync & hist2) | (hist1 & hist2);
`else
  assign sample = rx_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    load      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = sample ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          shreg_nxt = {sample, shreg[DW-1:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets the next start edge be caught without an idle gap.
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          if (sample) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BRK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BRK: begin
        if (rx_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_par    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      frame_err <= ferr_set;
      overrun   <= load && rx_valid && !rx_ready;
      if (load) begin
        rx_par   <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
